// File: rtl/cond_unit.sv
// Condition unit: holds the architectural NZCV flags, evaluates the ARM condition
// field against them and gates the PC/register/memory write enables of the instruction.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       InstrStart,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags,
  output logic       CondEx
);

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       cond_ex_reg;
  logic       cond_ex_next;
  logic       ce;
  logic       g;
  logic       n_flag;
  logic       z_flag;
  logic       c_flag;
  logic       v_flag;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_reg;

  // Evaluation always uses the registered flags, so a flag-setting instruction
  // never sees its own ALU result.
  always_comb begin
    ce = 1'b0;
    unique case (Cond)
      4'b0000: ce = z_flag;
      4'b0001: ce = ~z_flag;
      4'b0010: ce = c_flag;
      4'b0011: ce = ~c_flag;
      4'b0100: ce = n_flag;
      4'b0101: ce = ~n_flag;
      4'b0110: ce = v_flag;
      4'b0111: ce = ~v_flag;
      4'b1000: ce = c_flag & ~z_flag;
      4'b1001: ce = ~c_flag | z_flag;
      4'b1010: ce = (n_flag == v_flag);
      4'b1011: ce = (n_flag != v_flag);
      4'b1100: ce = ~z_flag & (n_flag == v_flag);
      4'b1101: ce = z_flag | (n_flag != v_flag);
      4'b1110: ce = 1'b1;
      4'b1111: ce = 1'b0;
      default: ce = 1'b0;
    endcase
  end

  // Later cycles of a multi-cycle instruction reuse the verdict taken at decode.
  assign g = InstrStart ? ce : cond_ex_reg;

  always_comb begin
    flags_next   = flags_reg;
    cond_ex_next = cond_ex_reg;
    if (FlagW[1] && g) begin
      flags_next[3:2] = ALUFlags[3:2];
    end
    if (FlagW[0] && g) begin
      flags_next[1:0] = ALUFlags[1:0];
    end
    if (InstrStart) begin
      cond_ex_next = ce;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      flags_reg   <= RESET_FLAGS;
      cond_ex_reg <= 1'b0;
    end else begin
      flags_reg   <= flags_next;
      cond_ex_reg <= cond_ex_next;
    end
  end

  assign PCSrc    = PCS & g;
  assign RegWrite = RegW & g & ~NoWrite;
  assign MemWrite = MemW & g;
  assign Flags    = flags_reg;
  assign CondEx   = g;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed scenarios followed by random traffic,
// each cycle's expected outputs come from a behavioural NZCV model.
module tb_cond_unit;

  localparam logic [3:0] RST_FLAGS = 4'b0000;

  logic       clk;
  logic       rst;
  logic       instr_start;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_w;
  logic       pcs;
  logic       reg_w;
  logic       mem_w;
  logic       no_write;
  logic       pc_src;
  logic       reg_write;
  logic       mem_write;
  logic [3:0] flags;
  logic       cond_ex;

  cond_unit #(.RESET_FLAGS(RST_FLAGS)) dut (
    .CLK       (clk),
    .Reset     (rst),
    .InstrStart(instr_start),
    .Cond      (cond),
    .ALUFlags  (alu_flags),
    .FlagW     (flag_w),
    .PCS       (pcs),
    .RegW      (reg_w),
    .MemW      (mem_w),
    .NoWrite   (no_write),
    .PCSrc     (pc_src),
    .RegWrite  (reg_write),
    .MemWrite  (mem_write),
    .Flags     (flags),
    .CondEx    (cond_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [3:0] flags;
    logic       ce;
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
  } exp_t;

  exp_t sb[$];
  int   n_compared = 0;
  int   n_failed   = 0;
  int   txn_id     = 0;

  // Reference state
  logic [3:0] m_flags;
  logic       m_latched;

  // Conditions come in predicate/negation pairs; bit 0 selects the negation.
  function automatic logic model_cond(input logic [3:0] f, input logic [3:0] c);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c >> 1)
      0: base = z;
      1: base = cy;
      2: base = n;
      3: base = v;
      4: base = cy && !z;
      5: base = (n == v);
      6: base = !z && (n == v);
      default: base = 1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic model_g();
    return instr_start ? model_cond(m_flags, cond) : m_latched;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic gg;
    logic cev;
    if (rst) begin
      m_flags   = RST_FLAGS;
      m_latched = 1'b0;
    end else begin
      cev = model_cond(m_flags, cond);
      gg  = model_g();
      if (flag_w[1] && gg) m_flags[3:2] = alu_flags[3:2];
      if (flag_w[0] && gg) m_flags[1:0] = alu_flags[1:0];
      if (instr_start) m_latched = cev;
    end
  endtask

  task automatic step(input logic r, input logic is, input logic [3:0] c,
                      input logic [3:0] af, input logic [1:0] fw, input logic p,
                      input logic rw, input logic mw, input logic nw);
    exp_t e;
    logic gg;
    @(posedge clk);
    model_edge();
    #1;
    rst = r; instr_start = is; cond = c; alu_flags = af; flag_w = fw;
    pcs = p; reg_w = rw; mem_w = mw; no_write = nw;
    gg = model_g();
    e.id       = txn_id;
    e.flags    = m_flags;
    e.ce       = gg;
    e.pcsrc    = p && gg;
    e.regwrite = rw && gg && !nw;
    e.memwrite = mw && gg;
    sb.push_back(e);
    txn_id++;
  endtask

  task automatic check_bit(input string name, input int id, input logic act, input logic req);
    n_compared++;
    if (act !== req) begin
      n_failed++;
      $display("FAIL txn %0d %s: got %b expected %b", id, name, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents one transaction.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_compared++;
      if (flags !== e.flags) begin
        n_failed++;
        $display("FAIL txn %0d flags: got %b expected %b", e.id, flags, e.flags);
      end
      check_bit("condex",   e.id, cond_ex,   e.ce);
      check_bit("pcsrc",    e.id, pc_src,    e.pcsrc);
      check_bit("regwrite", e.id, reg_write, e.regwrite);
      check_bit("memwrite", e.id, mem_write, e.memwrite);
      $display("txn %0d rst=%b is=%b cond=%h flags=%b condex=%b pcs/rw/mw=%b%b%b",
               e.id, rst, instr_start, cond, flags, cond_ex, pc_src, reg_write, mem_write);
    end
  end

  initial begin
    rst = 1'b1; instr_start = 1'b0; cond = 4'h0; alu_flags = 4'h0; flag_w = 2'b00;
    pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
    m_flags = 4'bxxxx; m_latched = 1'bx;

    // Reset, then EQ/NE against zero flags
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0);
    step(0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
    step(0, 1, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0);
    // Flag write then EQ taken
    step(0, 1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
    step(0, 1, 4'h0, 4'h0, 2'b00, 0, 0, 1, 0);
    // Split update
    step(1, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    step(0, 1, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0);
    step(0, 1, 4'hE, 4'b0011, 2'b01, 0, 0, 0, 0);
    step(0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0);
    // Latched verdict survives a flag change mid-instruction
    step(0, 1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
    step(0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
    step(0, 0, 4'h0, 4'h0, 2'b11, 0, 1, 0, 0);
    step(0, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0);
    step(0, 0, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0);
    // Signed and compound conditions
    step(0, 1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
    for (int c = 10; c <= 13; c++) step(0, 1, 4'(c), 4'h0, 2'b00, 0, 1, 0, 0);
    step(0, 1, 4'hE, 4'b0010, 2'b11, 0, 0, 0, 0);
    step(0, 1, 4'h8, 4'h0, 2'b00, 0, 1, 0, 0);
    step(0, 1, 4'h9, 4'h0, 2'b00, 0, 1, 0, 0);
    step(0, 1, 4'hF, 4'h0, 2'b00, 1, 1, 1, 0);
    // NoWrite compare, then reset colliding with a flag write
    step(0, 1, 4'hE, 4'b1010, 2'b11, 0, 1, 0, 1);
    step(1, 1, 4'hE, 4'b0101, 2'b11, 1, 1, 1, 0);
    step(0, 0, 4'h0, 4'h0, 2'b11, 1, 1, 1, 0);
    step(0, 0, 4'h0, 4'h0, 2'b00, 1, 1, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 2) == 0),
           4'($urandom), 4'($urandom), 2'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    n_compared++;
    if (sb.size() != 0) begin
      n_failed++;
      $display("FAIL drain: %0d transactions unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Consumer end of the ALU flag interface. Holds the architectural NZCV flags register and evaluates all 16 ARM condition codes against it.
- Gates the PC, register-file and memory write enables of the current instruction.
- Sits between the decoder/controller and the datapath of the multi-cycle core. In single-cycle use, InstrStart is tied high.
- Latches the condition result once per instruction, so a flag-setting conditional instruction keeps its original verdict for all of its cycles.

Parameters:
- RESET_FLAGS, 4'b0000, value loaded into {N,Z,C,V} on reset.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- InstrStart  input  1  high in the decode cycle of each instruction; tie high for single-cycle use.
- Cond  input  4  instruction condition field Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU in the current cycle.
- FlagW  input  2  [1]: request N,Z update; [0]: request C,V update.
- PCS  input  1  instruction writes PC.
- RegW  input  1  instruction writes register file.
- MemW  input  1  instruction writes memory.
- NoWrite  input  1  compare-type instruction; suppress RegWrite.
- PCSrc  output  1  gated PC write/select.
- RegWrite  output  1  gated register write enable.
- MemWrite  output  1  gated memory write enable.
- Flags  output  4  current registered {N,Z,C,V}.
- CondEx  output  1  effective condition result G (see below).

Behaviour:
- State:
  - Flags register, 4 bits, bit order {N,Z,C,V}.
  - CondExR, 1 bit.
  - No other state.
- Reset (synchronous, Reset=1 at the edge):
  - Flags <= RESET_FLAGS; CondExR <= 0.
  - Reset has priority over every update in the same cycle.
  - Reset mid-instruction discards the latched verdict.
- Condition evaluation (combinational, uses the registered Flags only, never ALUFlags), giving CE:
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1. 1111: 0 (reserved, never executes).
- Effective condition:
  - G = InstrStart ? CE : CondExR.
  - CondEx output = G.
- Latch: on an edge with InstrStart=1 and Reset=0, CondExR <= CE. Otherwise CondExR holds.
- Outputs (combinational, zero latency from inputs):
  - PCSrc = PCS & G.
  - RegWrite = RegW & G & ~NoWrite.
  - MemWrite = MemW & G.
- Flag update (at the edge, Reset=0):
  - If FlagW[1] & G: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0] & G: Flags[1:0] <= ALUFlags[1:0].
  - Each half updates independently.
  - The new flags become visible on Flags the cycle after the update edge. They are used by the next instruction's evaluation, never by the current one.
- Simultaneous events:
  - InstrStart=1 with FlagW set: evaluation uses the pre-update Flags and the update is gated by that same CE. This is the single-cycle ADDEQS case.
  - G=0: all three outputs are 0 and Flags holds regardless of FlagW.
- Reset output values:
  - Flags = RESET_FLAGS; CondExR = 0.
  - With InstrStart=0, PCSrc, RegWrite, MemWrite and CondEx all read 0.
- X-free: every Cond value, including 1111, yields a defined CE.

Test Plan:
- Reset with RESET_FLAGS=0, then InstrStart=1, Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0. With Cond=0001 (NE) -> CondEx=1, RegWrite=1.
- Flag write: Cond=1110, FlagW=11, ALUFlags=0100 -> Flags=0100 next cycle. Then Cond=0000, MemW=1 -> MemWrite=1.
- Split update:
  - Flags=0000, FlagW=10, ALUFlags=1111 -> Flags=1100.
  - Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Latch hold:
  - Flags=0100, InstrStart=1, Cond=0000 -> CondExR=1.
  - In the same instruction's later cycles (InstrStart=0), FlagW=11, ALUFlags=0000 updates Flags to 0000.
  - Following cycles still give CondEx=1 and RegWrite=1 (RegW=1) until the next InstrStart.
- Signed and compound conditions against Flags=1000 (N=1,V=0):
  - GE -> 0; LT -> 1; GT -> 0; LE -> 1.
  - With Flags=0010: HI -> 1, LS -> 0.
  - Cond=1111 -> 0 for any Flags.
- NoWrite and Reset:
  - Cond=1110, RegW=1, NoWrite=1, FlagW=11 -> RegWrite=0 and Flags updated.
  - Reset asserted in the same cycle as FlagW=11 -> Flags=RESET_FLAGS and CondExR=0 next cycle.
